// File: rtl/dotproduct_stream_pkg.sv
// dotproduct_pkg: shared widths, state encoding and accumulator limits for dotproduct_stream.
// Widths come from the `N, `DATA_WIDTH and `ACC_WIDTH macros. The defaults below apply
// when those macros are not set on the command line.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 20
`endif
package dotproduct_pkg;
    localparam int N          = `N;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int ACC_WIDTH  = `ACC_WIDTH;
    localparam int IDX_WIDTH  = $clog2(N) + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    typedef enum logic {ACCUM, OUTPUT} state_t;
endpackage

// File: rtl/dotproduct_stream_if.sv
// dotproduct_stream_if: weight load, activation stream and result stream of dotproduct_stream.
// The master modport drives w_load, w_in, x_valid, x_data and dp_ready.
// The slave modport drives x_ready, dp_valid, dp and idx, plus sat when DOTPRODUCT_STREAM_SAT_EN is defined.
interface dotproduct_stream_if;
    import dotproduct_pkg::*;
    logic                          w_load;
    logic [N*DATA_WIDTH-1:0]       w_in;
    logic                          x_valid;
    logic                          x_ready;
    logic signed [DATA_WIDTH-1:0]  x_data;
    logic                          dp_valid;
    logic                          dp_ready;
    logic signed [ACC_WIDTH-1:0]   dp;
    logic [IDX_WIDTH-1:0]          idx;
`ifdef DOTPRODUCT_STREAM_SAT_EN
    logic                          sat;
`endif
    modport master (
        output w_load, w_in, x_valid, x_data, dp_ready,
`ifdef DOTPRODUCT_STREAM_SAT_EN
        input  sat,
`endif
        input  x_ready, dp_valid, dp, idx
    );
    modport slave (
        input  w_load, w_in, x_valid, x_data, dp_ready,
`ifdef DOTPRODUCT_STREAM_SAT_EN
        output sat,
`endif
        output x_ready, dp_valid, dp, idx
    );
endinterface

// File: rtl/dotproduct_stream_mac_unit.sv
// mac_unit: combinational signed multiply-accumulate step (i_acc + i_x*i_w).
// Ports: i_x and i_w are the operands, i_acc is the addend, o_sum is the new sum,
// and o_sat flags a clipped step. o_sat exists only when DOTPRODUCT_STREAM_SAT_EN is defined.
module mac_unit
    import dotproduct_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
`ifdef DOTPRODUCT_STREAM_SAT_EN
    output logic                         o_sat,
`endif
    output logic signed [ACC_WIDTH-1:0]  o_sum
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    assign w_prod = i_x * i_w;
`ifdef DOTPRODUCT_STREAM_SAT_EN
    // The sum is computed one bit wider than either operand so that overflow is visible before clipping.
    localparam int SUM_WIDTH = (ACC_WIDTH > 2*DATA_WIDTH ? ACC_WIDTH : 2*DATA_WIDTH) + 1;
    localparam logic signed [SUM_WIDTH-1:0] HI = SUM_WIDTH'(ACC_MAX);
    localparam logic signed [SUM_WIDTH-1:0] LO = SUM_WIDTH'(ACC_MIN);
    logic signed [SUM_WIDTH-1:0] w_full;
    assign w_full = SUM_WIDTH'(w_prod) + SUM_WIDTH'(i_acc);
    assign o_sat  = (w_full > HI) || (w_full < LO);
    assign o_sum  = w_full > HI ? ACC_MAX : w_full < LO ? ACC_MIN : w_full[ACC_WIDTH-1:0];
`else
    assign o_sum = ACC_WIDTH'(w_prod) + i_acc;
`endif
endmodule

// File: rtl/dotproduct_stream.sv
// dotproduct_stream: element-serial dot product of a stored weight vector with an activation stream.
// Ports: clk is the clock. rst_n is a synchronous, active-low reset. bus is the slave side of dotproduct_stream_if.
// When DOTPRODUCT_STREAM_SAT_EN is defined, each step saturates and bus.sat reports any clip in the vector.
module dotproduct_stream
    import dotproduct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    dotproduct_stream_if.slave      bus
);
    state_t                       r_state;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_dp;
    logic [N*DATA_WIDTH-1:0]      r_w;
    logic [IDX_WIDTH-1:0]         r_idx;
    logic                         r_dp_valid;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [DATA_WIDTH-1:0] w_wsel;
    logic                         w_accept;
    logic                         w_last;
`ifdef DOTPRODUCT_STREAM_SAT_EN
    logic                         w_clip;
    logic                         r_vsat;
    logic                         r_sat;
    assign bus.sat = r_sat;
`endif
    // A weight load takes priority over an element arriving in the same cycle.
    assign bus.x_ready  = (r_state == ACCUM) && !bus.w_load;
    assign w_accept     = bus.x_valid && bus.x_ready;
    assign w_last       = r_idx == IDX_WIDTH'(N-1);
    assign w_wsel       = r_w[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.dp       = r_dp;
    assign bus.dp_valid = r_dp_valid;
    assign bus.idx      = r_idx;
    mac_unit u_mac (
        .i_x   (bus.x_data),
        .i_w   (w_wsel),
        .i_acc (r_acc),
`ifdef DOTPRODUCT_STREAM_SAT_EN
        .o_sat (w_clip),
`endif
        .o_sum (w_sum)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_idx      <= '0;
            r_dp_valid <= 1'b0;
            r_dp       <= '0;
            r_w        <= '0;
`ifdef DOTPRODUCT_STREAM_SAT_EN
            r_vsat     <= 1'b0;
            r_sat      <= 1'b0;
`endif
        end else begin
            if (bus.w_load && r_state == ACCUM && r_idx == '0)
                r_w <= bus.w_in;
            if (w_accept) begin
                r_acc <= w_last ? '0 : w_sum;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_dp       <= w_sum;
                    r_dp_valid <= 1'b1;
                    r_state    <= OUTPUT;
                end
`ifdef DOTPRODUCT_STREAM_SAT_EN
                // The sticky per-vector flag is published with dp, and the published flag clears when the next vector starts.
                r_vsat <= w_last ? 1'b0 : r_vsat | w_clip;
                r_sat  <= w_last ? r_vsat | w_clip : (r_idx == '0 ? 1'b0 : r_sat);
`endif
            end else if (r_dp_valid && bus.dp_ready) begin
                r_dp_valid <= 1'b0;
                r_state    <= ACCUM;
            end
        end
    end
endmodule

// File: tb/tb_dotproduct_stream.sv
// tb_dotproduct_stream: randomized, self-checking bench for dotproduct_stream using a queue-based reference model.
module tb_dotproduct_stream;
    import dotproduct_pkg::*;
    localparam int NW = N*DATA_WIDTH;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    dotproduct_stream_if bus();
    dotproduct_stream dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    int n_hs = 0;
    logic [NW-1:0]                m_w;
    logic signed [DATA_WIDTH-1:0] xq[$];
    logic                         m_busy;
    logic signed [ACC_WIDTH-1:0]  m_exp;
    logic                         m_sat;
    logic                         s_xready, s_dpv, s_sat, e_ready, e_dpv, e_sat;
    logic signed [ACC_WIDTH-1:0]  s_dp, e_dp;
    int                           s_idx, e_idx;
    logic signed [ACC_WIDTH-1:0]  want;
    localparam logic [NW-1:0] W1    = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [NW-1:0] X1    = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [NW-1:0] W_ONE = {8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [NW-1:0] W2    = {8'd0, 8'd3, 8'hFF, 8'd2};
    localparam logic [NW-1:0] W3    = {8'd5, 8'd5, 8'd5, 8'd5};

    // Reference dot product: plain integer arithmetic, either wrapped modulo 2^ACC_WIDTH or clipped after each step.
    function automatic void ref_dp(input logic [NW-1:0] wv, input logic signed [DATA_WIDTH-1:0] xs[$],
                                   output logic signed [ACC_WIDTH-1:0] r, output logic s);
        longint acc, hi, lo;
        acc = 0;
        hi = (longint'(1) <<< (ACC_WIDTH-1)) - 1;
        lo = -(longint'(1) <<< (ACC_WIDTH-1));
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc += longint'($signed(wv[i*DATA_WIDTH +: DATA_WIDTH])) * longint'(xs[i]);
`ifdef DOTPRODUCT_STREAM_SAT_EN
            if (acc > hi) begin acc = hi; s = 1'b1; end
            else if (acc < lo) begin acc = lo; s = 1'b1; end
`endif
        end
        r = acc[ACC_WIDTH-1:0];
    endfunction

    task automatic model_clear;
        m_w = '0; xq.delete(); m_busy = 1'b0; m_exp = '0; m_sat = 1'b0;
    endtask

    // Drives one cycle's inputs, records what is observed before the edge together with the model's expectation, and advances the model over the edge.
    task automatic tick(input logic wl, input logic [NW-1:0] wv, input logic xv,
                        input logic signed [DATA_WIDTH-1:0] xd, input logic dr);
        logic signed [ACC_WIDTH-1:0] r;
        logic s;
        bus.w_load = wl; bus.w_in = wv; bus.x_valid = xv; bus.x_data = xd; bus.dp_ready = dr;
        #1;
        s_xready = bus.x_ready; s_dpv = bus.dp_valid; s_dp = bus.dp; s_idx = int'(bus.idx);
`ifdef DOTPRODUCT_STREAM_SAT_EN
        s_sat = bus.sat;
`else
        s_sat = 1'b0;
`endif
        e_ready = !m_busy && !wl; e_dpv = m_busy; e_dp = m_exp; e_idx = xq.size(); e_sat = m_sat;
        if (wl && !m_busy && xq.size() == 0) m_w = wv;
        if (m_busy && dr) begin
            m_busy = 1'b0; n_hs++;
        end else if (xv && e_ready) begin
            xq.push_back(xd);
            if (xq.size() == 1) m_sat = 1'b0;
            if (xq.size() == N) begin
                ref_dp(m_w, xq, r, s);
                m_exp = r; m_sat = s; m_busy = 1'b1; xq.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.w_load = 1'b0; bus.w_in = '0; bus.x_valid = 1'b0; bus.x_data = '0; bus.dp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run_vec(input logic [NW-1:0] wv, input logic [NW-1:0] xs);
        tick(1'b1, wv, 1'b0, '0, 1'b1);
        for (int i = 0; i < N; i++) tick(1'b0, wv, 1'b1, xs[i*DATA_WIDTH +: DATA_WIDTH], 1'b1);
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (bus.dp_valid !== 1'b0) begin bad++; $display("FAIL reset_dp_valid got=%b want=0", bus.dp_valid); end
        total++; if (bus.dp !== '0) begin bad++; $display("FAIL reset_dp got=%0d want=0", bus.dp); end
        total++; if (bus.idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.idx); end
        total++; if (bus.x_ready !== 1'b1) begin bad++; $display("FAIL reset_x_ready got=%b want=1", bus.x_ready); end
        bus.w_load = 1'b1; #1;
        total++; if (bus.x_ready !== 1'b0) begin bad++; $display("FAIL load_blocks_ready got=%b want=0", bus.x_ready); end
        bus.w_load = 1'b0;
    endtask

    task automatic test_basic;
        tick(1'b1, W1, 1'b0, '0, 1'b1);
        for (int i = 0; i < N; i++) begin
            tick(1'b0, W1, 1'b1, X1[i*DATA_WIDTH +: DATA_WIDTH], 1'b1);
            total++; if (s_xready !== 1'b1) begin bad++; $display("FAIL basic_ready[%0d] got=%b want=1", i, s_xready); end
            if (i == 1) begin
                total++; if (bus.idx !== 2) begin bad++; $display("FAIL basic_idx got=%0d want=2", bus.idx); end
            end
        end
        want = 70;
        total++; if (bus.dp_valid !== 1'b1) begin bad++; $display("FAIL basic_dp_valid got=%b want=1", bus.dp_valid); end
        total++; if (bus.dp !== want) begin bad++; $display("FAIL basic_dp got=%0d want=%0d", bus.dp, want); end
        total++; if (bus.x_ready !== 1'b0) begin bad++; $display("FAIL basic_out_ready got=%b want=0", bus.x_ready); end
        total++; if (bus.idx !== '0) begin bad++; $display("FAIL basic_idx_wrap got=%0d want=0", bus.idx); end
        tick(1'b0, W1, 1'b1, 8'sd9, 1'b1);
        total++; if (s_xready !== 1'b0) begin bad++; $display("FAIL hs_cycle_ready got=%b want=0", s_xready); end
        total++; if (bus.dp_valid !== 1'b0) begin bad++; $display("FAIL hs_dp_valid got=%b want=0", bus.dp_valid); end
        total++; if (bus.dp !== want) begin bad++; $display("FAIL hs_dp_hold got=%0d want=%0d", bus.dp, want); end
        total++; if (bus.idx !== '0) begin bad++; $display("FAIL hs_no_accept got=%0d want=0", bus.idx); end
    endtask

    task automatic test_extremes;
        run_vec({N{8'h80}}, {N{8'h80}});
        want = 65536;
        total++; if (bus.dp !== want || bus.dp_valid !== 1'b1) begin bad++; $display("FAIL ext_neg_neg got=%0d want=%0d", bus.dp, want); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
        run_vec({N{8'h7F}}, {N{8'h80}});
        want = -65024;
        total++; if (bus.dp !== want || bus.dp_valid !== 1'b1) begin bad++; $display("FAIL ext_pos_neg got=%0d want=%0d", bus.dp, want); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_back_pressure;
        run_vec(W1, X1);
        want = 70;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, W3, 1'b1, 8'sd3, 1'b0);
            total++; if (s_dpv !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, s_dpv); end
            total++; if (s_dp !== want) begin bad++; $display("FAIL bp_dp[%0d] got=%0d want=%0d", i, s_dp, want); end
            total++; if (s_xready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, s_xready); end
        end
        tick(1'b0, W3, 1'b1, 8'sd3, 1'b1);
        total++; if (s_xready !== 1'b0 || bus.dp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b want=0/0", s_xready, bus.dp_valid); end
        for (int i = 0; i < N; i++) tick(1'b0, W3, 1'b1, X1[i*DATA_WIDTH +: DATA_WIDTH], 1'b1);
        total++; if (bus.dp !== want) begin bad++; $display("FAIL bp_old_weights got=%0d want=%0d", bus.dp, want); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_load_rules;
        tick(1'b1, W_ONE, 1'b0, '0, 1'b1);
        tick(1'b1, W2, 1'b1, 8'sd1, 1'b1);
        total++; if (s_xready !== 1'b0) begin bad++; $display("FAIL load_win_ready got=%b want=0", s_xready); end
        total++; if (bus.idx !== '0) begin bad++; $display("FAIL load_win_idx got=%0d want=0", bus.idx); end
        for (int i = 1; i <= N; i++) tick(1'b0, '0, 1'b1, 8'(i), 1'b1);
        want = 9;
        total++; if (bus.dp !== want) begin bad++; $display("FAIL load_new_w got=%0d want=%0d", bus.dp, want); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1, 8'sd1, 1'b1);
        tick(1'b0, '0, 1'b1, 8'sd1, 1'b1);
        tick(1'b1, W3, 1'b0, '0, 1'b1);
        total++; if (bus.idx !== 2) begin bad++; $display("FAIL load_mid_idx got=%0d want=2", bus.idx); end
        tick(1'b0, '0, 1'b1, 8'sd1, 1'b1);
        tick(1'b0, '0, 1'b1, 8'sd1, 1'b1);
        want = 4;
        total++; if (bus.dp !== want) begin bad++; $display("FAIL load_mid_ignored got=%0d want=%0d", bus.dp, want); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid;
        tick(1'b1, W1, 1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1, 8'sd5, 1'b1);
        tick(1'b0, '0, 1'b1, 8'sd6, 1'b1);
        do_reset();
        total++; if (bus.idx !== '0) begin bad++; $display("FAIL rmid_idx got=%0d want=0", bus.idx); end
        total++; if (bus.dp_valid !== 1'b0 || bus.dp !== '0) begin bad++; $display("FAIL rmid_out got=%b/%0d want=0/0", bus.dp_valid, bus.dp); end
        for (int i = 0; i < N; i++) tick(1'b0, '0, 1'b1, X1[i*DATA_WIDTH +: DATA_WIDTH], 1'b1);
        total++; if (bus.dp !== '0 || bus.dp_valid !== 1'b1) begin bad++; $display("FAIL rmid_zero_w got=%0d want=0", bus.dp); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
        run_vec(W1, X1);
        want = 70;
        total++; if (bus.dp !== want) begin bad++; $display("FAIL rmid_reload got=%0d want=%0d", bus.dp, want); end
        do_reset();
        total++; if (bus.dp_valid !== 1'b0 || bus.x_ready !== 1'b1) begin bad++; $display("FAIL rout_discard got=%b/%b want=0/1", bus.dp_valid, bus.x_ready); end
    endtask

`ifdef DOTPRODUCT_STREAM_SAT_EN
    task automatic test_sat;
        run_vec({N{8'h7F}}, {N{8'h7F}});
        total++; if (bus.dp !== m_exp || bus.sat !== m_sat) begin bad++; $display("FAIL sat_pos got=%0d/%b want=%0d/%b", bus.dp, bus.sat, m_exp, m_sat); end
        tick(1'b0, '0, 1'b0, '0, 1'b1);
    endtask
`endif

    task automatic test_random;
        int cyc = 0;
        int goal = n_hs + 1000;
        while (n_hs < goal && cyc < 40000) begin
            tick($urandom_range(0, 9) == 0, NW'({$urandom(), $urandom()}), $urandom_range(0, 9) < 7,
                 DATA_WIDTH'($urandom()), $urandom_range(0, 9) < 6);
            total++; if (s_xready !== e_ready) begin bad++; $display("FAIL rnd_ready c%0d got=%b want=%b", cyc, s_xready, e_ready); end
            total++; if (s_dpv !== e_dpv) begin bad++; $display("FAIL rnd_valid c%0d got=%b want=%b", cyc, s_dpv, e_dpv); end
            total++; if (s_idx !== e_idx) begin bad++; $display("FAIL rnd_idx c%0d got=%0d want=%0d", cyc, s_idx, e_idx); end
            total++; if (s_sat !== e_sat) begin bad++; $display("FAIL rnd_sat c%0d got=%b want=%b", cyc, s_sat, e_sat); end
            if (e_dpv) begin
                total++; if (s_dp !== e_dp) begin bad++; $display("FAIL rnd_dp c%0d got=%0d want=%0d", cyc, s_dp, e_dp); end
            end
            cyc++;
        end
        total++; if (n_hs < goal) begin bad++; $display("FAIL rnd_timeout got=%0d want=%0d", n_hs, goal); end
    endtask

    initial begin
        bus.w_load = 1'b0; bus.w_in = '0; bus.x_valid = 1'b0; bus.x_data = '0; bus.dp_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_extremes();
        test_back_pressure();
        test_load_rules();
        test_reset_mid();
`ifdef DOTPRODUCT_STREAM_SAT_EN
        test_sat();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dotproduct_stream.md
Name: dotproduct_stream

Overview:
- Sequential, element-serial counterpart of the combinational DotProduct block.
- Holds a packed weight vector. Consumes activation elements one per cycle over a valid/ready stream, accumulating with a single MAC.
- Emits one ACC_WIDTH result per N elements on a valid/ready output.
- Feeds the accumulation/output stage where a full N-wide parallel multiplier array is too costly. For any given vectors, the result must bit-match DotProduct.

Parameters:
- N, `N, number of elements per dot product (≥1).
- DATA_WIDTH, `DATA_WIDTH, signed element width.
- ACC_WIDTH, `ACC_WIDTH, signed accumulator/result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- w_load  in  1  load w_in into the weight register (pulse).
- w_in  in  N*DATA_WIDTH  packed signed weights; element i at [i*DATA_WIDTH +: DATA_WIDTH].
- x_valid  in  1  activation element valid.
- x_ready  out  1  block can accept an element.
- x_data  in  DATA_WIDTH  signed activation element.
- dp_valid  out  1  result valid.
- dp_ready  in  1  downstream accepts result.
- dp  out  ACC_WIDTH  signed dot-product result.
- idx  out  $clog2(N)+1  count of elements accepted in the current vector (debug/status).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=ACCUM, acc=0, idx=0, dp_valid=0, dp=0.
  - Weight register cleared to 0.
  - Reset mid-vector or mid-output discards the partial sum or pending result; no output handshake completes.
- States: ACCUM and OUTPUT.
- x_ready = (state==ACCUM) && !w_load, combinational.
- Element accept: x_valid && x_ready.
  - acc ← acc + sext(x_data × w[idx]).
  - idx ← idx+1.
- Accept when idx==N-1:
  - dp ← final sum; dp_valid ← 1; state ← OUTPUT; idx ← 0; acc ← 0.
  - Latency: dp_valid asserts the cycle after the last element is accepted.
- OUTPUT:
  - x_ready=0.
  - dp and dp_valid are held stable until dp_ready is sampled high.
  - On dp_valid && dp_ready: dp_valid ← 0, state ← ACCUM. The next element is accepted no earlier than the following cycle.
  - dp holds its last value after the handshake.
- Weight load:
  - Honoured only when state==ACCUM and idx==0; the weight register updates that edge.
  - Ignored otherwise. Weights are stable for a whole vector.
  - w_load and x_valid in the same cycle: load wins (x_ready=0), and the element is taken next cycle with the new weights.
- Arithmetic:
  - Product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH, matching DotProduct.
- Back-pressure: x_valid gaps are allowed, and idx/acc hold while no accept occurs.
- N==1: every accepted element produces a result.

Optional Feature:
- Macro: DOTPRODUCT_STREAM_SAT_EN.
- Defined:
  - Each accumulate step saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Extra output port `sat` (1 bit) is set when any step of the current vector clipped. It is presented and held alongside dp and cleared on reset or on the next vector start.
- Undefined: wrap-around arithmetic as above; no `sat` port.

Decomposition:
- Package dotproduct_pkg:
  - State enum (ACCUM, OUTPUT).
  - ACC_MAX/ACC_MIN constants.
  - IDX_WIDTH = $clog2(N)+1.
  - Widths taken from width.svh macros.
- Sub-module mac_unit (combinational): signed DATA_WIDTH × DATA_WIDTH product plus ACC_WIDTH addend. Saturation logic lives there under the macro.
- Top module holds the FSM, counters and registers.

Test Plan:
All scenarios use N=4, DATA_WIDTH=8, ACC_WIDTH=20.
- Basic: load w={1,2,3,4}, stream x={5,6,7,8} back-to-back with dp_ready=1 → dp_valid one cycle after 4th accept, dp=70; x_ready=0 during OUTPUT.
- Signed extremes: w all -128, x all -128 → dp=65536; w all 127, x all -128 → dp=-65024.
- Back-pressure: hold dp_ready=0 for 5 cycles after result → dp and dp_valid stable, x_ready=0 throughout; new vector accepted only after the handshake.
- Load rules: w_load with x_valid at idx=0 → x_ready=0 that cycle and new weights used. w_load at idx=2 → ignored, result uses old weights.
- Reset mid-vector: rst_n low after 2 accepts → idx=0, acc=0, dp_valid=0, weights 0; a subsequent full vector with weights reloaded gives the correct dp.
- Random (wrap mode): 1000 random vectors with random valid/ready gaps → every dp equals the DotProduct reference model bit-exactly. With DOTPRODUCT_STREAM_SAT_EN and ACC_WIDTH=16: w,x all 127 → dp=32767, sat=1.
